// File: rtl/scan_addr_sequencer_if.sv
// ----------------------------------------------------------------------------
// scan_addr_sequencer_if
// Control and status bundle between a scan controller (master) and the
// scan_addr_sequencer (slave), which in turn feeds a line decoder.
//
// Parameters:
//   ADDR_W   width of the decoder select address
//   DWELL_W  width of the per-address dwell count
//
// Signals:
//   start       master -> slave  begin a scan (honoured only when idle)
//   stop        master -> slave  graceful stop at the next period boundary
//   continuous  master -> slave  1 = wrap and repeat, 0 = single pass
//   dwell       master -> slave  cycles per address (0 behaves as 1)
//   addr        slave -> master  registered decoder select address
//   addr_en     slave -> master  registered decoder enable strobe
//   busy        slave -> master  scan in progress
//   wrap        slave -> master  pulse on the last cycle of the top address
//   done        slave -> master  pulse on the cycle the scan returns to idle
// ----------------------------------------------------------------------------
interface scan_addr_sequencer_if #(
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               continuous;
    logic [DWELL_W-1:0] dwell;
    logic [ADDR_W-1:0]  addr;
    logic               addr_en;
    logic               busy;
    logic               wrap;
    logic               done;

    // Controller side: issues commands, observes the scan.
    modport master (
        output start,
        output stop,
        output continuous,
        output dwell,
        input  addr,
        input  addr_en,
        input  busy,
        input  wrap,
        input  done
    );

    // Sequencer side: consumes commands, drives the decoder select.
    modport slave (
        input  start,
        input  stop,
        input  continuous,
        input  dwell,
        output addr,
        output addr_en,
        output busy,
        output wrap,
        output done
    );
endinterface

// File: rtl/scan_addr_sequencer.sv
// ----------------------------------------------------------------------------
// scan_addr_sequencer
// Upstream address source for a one-hot line decoder. Steps a select address
// through 0..2^ADDR_W-1, holding each address for a programmable number of
// cycles, and drives an enable strobe that gates the decoder outputs
// (display-digit or keypad-row scanning). Supports single-pass and
// continuous scanning with a graceful stop.
//
// Optional feature (macro SCAN_BLANK_EN):
//   When defined, every non-terminal address advance (including the
//   max -> 0 wrap in continuous mode) is followed by BLANK_CYCLES cycles with
//   addr_en low while addr already shows the next address. No blanking is
//   inserted before returning to idle. When undefined, addresses advance
//   back-to-back with addr_en continuously high.
//
// Parameters (must match the widths of the connected interface):
//   ADDR_W        select address width
//   DWELL_W       dwell count width
//   BLANK_CYCLES  blank cycles between addresses (>= 1, SCAN_BLANK_EN only)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts a scan without a done pulse
//   bus    scan_addr_sequencer_if.slave: start/stop/continuous/dwell in,
//          addr/addr_en/busy/wrap/done out (all outputs registered)
// ----------------------------------------------------------------------------
module scan_addr_sequencer #(
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned DWELL_W      = 8,
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    scan_addr_sequencer_if.slave   bus
);

    // Reject a blanking length that would make BLANK unreachable-to-exit.
    if (BLANK_CYCLES < 1) begin : g_bad_blank_cycles
        $error("scan_addr_sequencer: BLANK_CYCLES must be >= 1");
    end

    localparam logic [ADDR_W-1:0]  ADDR_MAX  = '1;
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DWELL = 2'd1;
`ifdef SCAN_BLANK_EN
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam int unsigned BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
`endif

    // Architectural state and registered outputs.
    logic [1:0]         state_q,        state_d;
    logic [ADDR_W-1:0]  addr_q,         addr_d;
    logic               addr_en_q,      addr_en_d;
    logic               busy_q,         busy_d;
    logic               wrap_q,         wrap_d;
    logic               done_q,         done_d;
    logic [DWELL_W-1:0] cnt_q,          cnt_d;
    logic [DWELL_W-1:0] dwell_q,        dwell_d;
    logic               cont_q,         cont_d;
    logic               stop_pending_q, stop_pending_d;
`ifdef SCAN_BLANK_EN
    logic [BLANK_W-1:0] blank_cnt_q,    blank_cnt_d;
`endif

    // Helper terms for the DWELL state.
    logic period_end_c;
    logic finish_c;

    assign period_end_c = (cnt_q == (dwell_q - DWELL_ONE));
    // A stop on the last cycle of a period terminates at that same boundary.
    assign finish_c     = stop_pending_q || bus.stop || ((addr_q == ADDR_MAX) && !cont_q);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            addr_en_q      <= 1'b0;
            busy_q         <= 1'b0;
            wrap_q         <= 1'b0;
            done_q         <= 1'b0;
            cnt_q          <= '0;
            dwell_q        <= '0;
            cont_q         <= 1'b0;
            stop_pending_q <= 1'b0;
`ifdef SCAN_BLANK_EN
            blank_cnt_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            addr_en_q      <= addr_en_d;
            busy_q         <= busy_d;
            wrap_q         <= wrap_d;
            done_q         <= done_d;
            cnt_q          <= cnt_d;
            dwell_q        <= dwell_d;
            cont_q         <= cont_d;
            stop_pending_q <= stop_pending_d;
`ifdef SCAN_BLANK_EN
            blank_cnt_q    <= blank_cnt_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        addr_en_d      = addr_en_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        cnt_d          = cnt_q;
        dwell_d        = dwell_q;
        cont_d         = cont_q;
        stop_pending_d = stop_pending_q;
`ifdef SCAN_BLANK_EN
        blank_cnt_d    = blank_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                addr_d         = '0;
                addr_en_d      = 1'b0;
                busy_d         = 1'b0;
                cnt_d          = '0;
                stop_pending_d = 1'b0;
                // stop is meaningless here; start always wins.
                if (bus.start) begin
                    state_d   = ST_DWELL;
                    addr_en_d = 1'b1;
                    busy_d    = 1'b1;
                    dwell_d   = (bus.dwell == '0) ? DWELL_ONE : bus.dwell;
                    cont_d    = bus.continuous;
                end
            end

            ST_DWELL: begin
                if (bus.stop) begin
                    stop_pending_d = 1'b1;
                end
                if (period_end_c) begin
                    cnt_d = '0;
                    if (finish_c) begin
                        state_d        = ST_IDLE;
                        addr_d         = '0;
                        addr_en_d      = 1'b0;
                        busy_d         = 1'b0;
                        done_d         = 1'b1;
                        stop_pending_d = 1'b0;
                    end else begin
                        // Natural modulo wrap covers max -> 0 in continuous mode.
                        addr_d = addr_q + ADDR_W'(1);
`ifdef SCAN_BLANK_EN
                        state_d     = ST_BLANK;
                        addr_en_d   = 1'b0;
                        blank_cnt_d = '0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_ONE;
                end
            end

`ifdef SCAN_BLANK_EN
            ST_BLANK: begin
                // A stop here is honoured at the end of the following period.
                if (bus.stop) begin
                    stop_pending_d = 1'b1;
                end
                if (blank_cnt_q == BLANK_LAST) begin
                    state_d   = ST_DWELL;
                    addr_en_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    blank_cnt_d = blank_cnt_q + BLANK_W'(1);
                end
            end
`endif

            default: begin
                state_d        = ST_IDLE;
                addr_d         = '0;
                addr_en_d      = 1'b0;
                busy_d         = 1'b0;
                cnt_d          = '0;
                stop_pending_d = 1'b0;
            end
        endcase

        // wrap is registered, so it is armed when the coming cycle will be
        // the final cycle of the top address.
        wrap_d = (state_d == ST_DWELL) && (addr_d == ADDR_MAX) &&
                 (cnt_d == (dwell_d - DWELL_ONE));
    end

    assign bus.addr    = addr_q;
    assign bus.addr_en = addr_en_q;
    assign bus.busy    = busy_q;
    assign bus.wrap    = wrap_q;
    assign bus.done    = done_q;

    // Structural invariants of the registered outputs.
    a_wrap_on_top_addr: assert property (@(posedge clk) disable iff (!rst_n)
        wrap_q |-> (addr_en_q && (addr_q == ADDR_MAX)));

    a_done_means_idle: assert property (@(posedge clk) disable iff (!rst_n)
        done_q |-> (!busy_q && !addr_en_q && (addr_q == '0)));

    a_enable_needs_busy: assert property (@(posedge clk) disable iff (!rst_n)
        addr_en_q |-> busy_q);

endmodule

// File: doc/scan_addr_sequencer.md
Name: scan_addr_sequencer

Overview:
- Upstream address source for the 2-to-4 line decoder. Steps a binary select address through 0..2^ADDR_W-1 and holds each address for a programmable dwell time.
- Drives an enable strobe so one-hot decoder outputs are gated, e.g. for display-digit or keypad-row scanning.
- Supports single-pass and continuous scanning, with start/stop control and status pulses.

Parameters:
ADDR_W, 2, width of the address driven into the decoder; scan range 0..2^ADDR_W-1
DWELL_W, 8, width of the dwell-count input
BLANK_CYCLES, 1, idle cycles between addresses (used only when SCAN_BLANK_EN is defined; must be >=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a scan; sampled only in IDLE
stop  input  1  request graceful stop; sampled in DWELL/BLANK
continuous  input  1  1 = wrap and repeat, 0 = single pass; latched on accepted start
dwell  input  DWELL_W  cycles per address; latched on accepted start; value 0 treated as 1
addr  output  ADDR_W  registered select address to the decoder
addr_en  output  1  registered; high while addr is valid and the decoder output should be asserted
busy  output  1  high from accepted start until return to IDLE
wrap  output  1  one-cycle pulse on the final cycle of address 2^ADDR_W-1
done  output  1  one-cycle pulse on the cycle the FSM returns to IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, addr=0, addr_en=0, busy=0, wrap=0, done=0, dwell counter=0, stop_pending=0, latched dwell/continuous=0. Asserting reset mid-scan aborts immediately with no done pulse.
- All outputs are registered; no combinational paths from inputs to outputs.
- FSM states: IDLE, DWELL, BLANK (BLANK exists only with SCAN_BLANK_EN).
- IDLE:
  - addr=0, addr_en=0, busy=0.
  - start=1 -> next cycle: state=DWELL, addr=0, addr_en=1, busy=1, cnt=0; dwell_q=max(dwell,1); cont_q=continuous.
  - stop is ignored in IDLE, including when it arrives together with start (start wins).
- DWELL:
  - addr_en=1 and cnt increments each cycle, so each address is held exactly dwell_q cycles.
  - start is ignored while busy.
  - stop=1 in any DWELL/BLANK cycle sets stop_pending.
  - End of period (cnt==dwell_q-1):
    - wrap=1 for that cycle if addr==2^ADDR_W-1.
    - If stop_pending, or (addr==max and cont_q==0): go to IDLE; done=1 next cycle; addr_en=0, busy=0, addr=0, stop_pending cleared.
    - Otherwise: addr<=addr+1 modulo 2^ADDR_W (max wraps to 0 when cont_q=1), cnt<=0, and stay in DWELL (or go to BLANK with the feature).
  - A stop asserted on the final cycle of a period takes effect at that same boundary.
- Timing:
  - Single pass, no blanking: addr_en high for exactly 2^ADDR_W*dwell_q consecutive cycles.
  - done is asserted one cycle after the last addr_en-high cycle.
- dwell and continuous inputs may change freely while busy; they have no effect until the next accepted start.

Optional Feature:
Macro SCAN_BLANK_EN.
- Defined:
  - On each non-terminal address advance, the FSM enters BLANK for BLANK_CYCLES cycles with addr_en=0; addr already shows the next address during BLANK.
  - It then returns to DWELL with addr_en=1 and cnt=0.
  - BLANK is also inserted on the max->0 wrap in continuous mode.
  - BLANK is not inserted before the return to IDLE.
  - A stop seen in BLANK is handled at the end of the next DWELL period.
- Undefined: no BLANK state; addresses advance back-to-back with addr_en continuously high.

Test Plan:
- Reset values: rst_n=0 for 3 cycles -> addr=0, addr_en=0, busy=0, wrap=0, done=0.
- Single pass: dwell=3, continuous=0, pulse start -> addr sequence 0,0,0,1,1,1,2,2,2,3,3,3 with addr_en high for 12 cycles; wrap on the 12th cycle; done on the 13th; busy low from the 13th.
- Continuous with stop:
  - Setup: dwell=2, continuous=1. Address 3 is followed by 0 with no gap, and wrap pulses every 8 cycles.
  - Stimulus: assert stop during the first cycle of the second visit to addr=1.
  - Response: that address completes its 2 cycles, then IDLE and done.
- dwell=0 and ignored start: dwell=0 behaves identically to dwell=1 (4 enable cycles, single pass). start pulsed while busy causes no restart.
- Async reset mid-scan: rst_n=0 during addr=2 -> outputs reset in the same cycle with no done pulse. start after release -> scan restarts at addr=0.
- SCAN_BLANK_EN build with BLANK_CYCLES=1, dwell=2, single pass -> addr_en pattern 1,1,0,1,1,0,1,1,0,1,1 (addr 0..3); done on the following cycle.
